// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/response bus.
// Single outstanding request, grant then rvalid.
interface fetch_ctrl_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding
// memory read, redirect with response kill.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   hold_flag_i,
  input  logic         jump_flag_i,
  input  logic [31:0]  jump_addr_i,
  fetch_ctrl_if.master mem,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_addr_o,
  output logic         inst_valid_o,
  output logic         fetch_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ra_q, ra_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        ivld_q, ivld_d;
  logic        req;
  logic        cap;
  logic        jump;
  logic        consume;

  assign consume = (hold_flag_i == 3'b000);
  assign jump    = jump_flag_i
                 && (state_q != S_IDLE);
  assign req     = (state_q == S_REQ)
                 && (!ivld_q || consume);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ra_d    = ra_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    iaddr_d = iaddr_q;
    ivld_d  = ivld_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (req && mem.mem_gnt_i) begin
          ra_d    = pc_q;
          state_d = S_WAIT;
          kill_d  = jump_flag_i;
        end
      end
      S_WAIT: begin
        if (mem.mem_rvalid_i) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          cap     = !kill_q && !jump_flag_i;
        end else if (jump_flag_i) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // redirect beats capture, capture beats consume
    if (jump) begin
      pc_d   = jump_addr_i & 32'hFFFF_FFFC;
      inst_d = NOP;
      ivld_d = 1'b0;
    end else if (cap) begin
      pc_d    = ra_q + 32'd4;
      inst_d  = mem.mem_rdata_i;
      iaddr_d = ra_q;
      ivld_d  = 1'b1;
    end else if (consume) begin
      inst_d = NOP;
      ivld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ra_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= NOP;
      iaddr_q <= 32'h0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ra_q    <= ra_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      iaddr_q <= iaddr_d;
      ivld_q  <= ivld_d;
    end
  end

  assign mem.mem_req_o  = req;
  assign mem.mem_addr_o = pc_q;
  assign inst_o         = inst_q;
  assign inst_addr_o    = iaddr_q;
  assign inst_valid_o   = ivld_q;
  assign fetch_busy_o   = (state_q == S_WAIT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hold = 3'b000;
  logic        jump = 1'b0;
  logic [31:0] jaddr = 32'h0;
  logic [31:0] inst, iaddr;
  logic        ivalid, busy;
  int          checks = 0;
  int          errors = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(RPC), .NOP(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold_flag_i  (hold),
    .jump_flag_i  (jump),
    .jump_addr_i  (jaddr),
    .mem          (bus),
    .inst_o       (inst),
    .inst_addr_o  (iaddr),
    .inst_valid_o (ivalid),
    .fetch_busy_o (busy)
  );

  always #5 clk = ~clk;

  // model state
  bit          m_started, m_out, m_kill, m_valid;
  logic [31:0] m_pc, m_raddr, m_inst, m_iaddr;
  int          lat;

  task automatic idle_in();
    hold = 3'b000; jump = 1'b0; jaddr = 32'h0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== RPC) begin errors++; $display("FAIL rst_addr got %h want %h", bus.mem_addr_o, RPC); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL rst_inst got %h want %h", inst, NOP); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %h want 0", iaddr); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ivalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    rst = 1'b0; bus.mem_gnt_i = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL basic_req got %b want 1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL basic_addr got %h want 0", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i = 32'h00A00093;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_noreq got %b want 0", bus.mem_req_o); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (inst !== 32'h00A00093) begin errors++; $display("FAIL basic_inst got %h want 00a00093", inst); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL basic_iaddr got %h want 0", iaddr); end
    checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", ivalid); end
    checks++; if (bus.mem_addr_o !== 32'h4) begin errors++; $display("FAIL basic_next got %h want 4", bus.mem_addr_o); end
  endtask

  task automatic test_hold();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      hold = 3'b010;
      bus.mem_rvalid_i = (i == 1);
      bus.mem_rdata_i = 32'h00100113;
      #1;
      if (i >= 2) begin
        checks++; if (inst !== 32'h00100113) begin errors++; $display("FAIL hold_inst[%0d] got %h want 00100113", i, inst); end
        checks++; if (iaddr !== 32'h4) begin errors++; $display("FAIL hold_iaddr[%0d] got %h want 4", i, iaddr); end
        checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b want 1", i, ivalid); end
        checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %b want 0", i, bus.mem_req_o); end
      end
    end
    @(negedge clk);
    hold = 3'b000; bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL unhold_req got %b want 1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h8) begin errors++; $display("FAIL unhold_addr got %h want 8", bus.mem_addr_o); end
  endtask

  task automatic test_jump_wait();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; jump = 1'b1; jaddr = 32'h0000_0102;
    @(negedge clk);
    jump = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL jw_busy got %b want 1", busy); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL jw_valid got %b want 0", ivalid); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (inst !== NOP) begin errors++; $display("FAIL jw_inst got %h want %h", inst, NOP); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL jw_valid2 got %b want 0", ivalid); end
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL jw_req got %b want 1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== 32'h100) begin errors++; $display("FAIL jw_addr got %h want 100", bus.mem_addr_o); end
  endtask

  task automatic test_jump_grant();
    bus.mem_gnt_i = 1'b1; jump = 1'b1; jaddr = 32'h0000_0200;
    #1;
    checks++; if (bus.mem_addr_o !== 32'h100) begin errors++; $display("FAIL jg_old got %h want 100", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; jump = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_1111;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL jg_busy got %b want 1", busy); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL jg_valid got %b want 0", ivalid); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL jg_inst got %h want %h", inst, NOP); end
    checks++; if (bus.mem_addr_o !== 32'h200) begin errors++; $display("FAIL jg_addr got %h want 200", bus.mem_addr_o); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jaddr = 32'hFFFF_FFFF; bus.mem_gnt_i = 1'b0;
    @(negedge clk);
    jump = 1'b0; bus.mem_gnt_i = 1'b1;
    #1;
    checks++; if (bus.mem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_tgt got %h want fffffffc", bus.mem_addr_o); end
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (inst !== 32'h1234_5678) begin errors++; $display("FAIL wrap_inst got %h want 12345678", inst); end
    checks++; if (iaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_iaddr got %h want fffffffc", iaddr); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", bus.mem_addr_o); end
  endtask

  task automatic test_reset_wait();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0; rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rw_idle got %b want 0", busy); end
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    #1;
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL rw_valid got %b want 0", ivalid); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL rw_inst got %h want %h", inst, NOP); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL rw_iaddr got %h want 0", iaddr); end
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL rw_req got %b want 1", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== RPC) begin errors++; $display("FAIL rw_addr got %h want %h", bus.mem_addr_o, RPC); end
  endtask

  // advance the reference model across one clock edge
  task automatic model_step();
    bit exp_req, take;
    exp_req = m_started && !m_out && (!m_valid || hold == 3'b000);
    if (!m_started) begin
      m_started = 1'b1;
    end else begin
      take = 1'b0;
      if (m_out && bus.mem_rvalid_i) begin
        m_out = 1'b0;
        take = !m_kill && !jump;
        m_kill = 1'b0;
      end else if (m_out && jump) begin
        m_kill = 1'b1;
      end else if (exp_req && bus.mem_gnt_i) begin
        m_out = 1'b1;
        m_raddr = m_pc;
        m_kill = jump;
        lat = $urandom_range(0, 2);
      end
      if (jump) begin
        m_pc = jaddr & 32'hFFFF_FFFC;
        m_valid = 1'b0; m_inst = NOP;
      end else if (take) begin
        m_inst = bus.mem_rdata_i; m_iaddr = m_raddr;
        m_valid = 1'b1; m_pc = m_raddr + 32'd4;
      end else if (hold == 3'b000) begin
        m_valid = 1'b0; m_inst = NOP;
      end
    end
  endtask

  task automatic test_random();
    bit e_req;
    idle_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    m_started = 0; m_out = 0; m_kill = 0; m_valid = 0;
    m_pc = RPC; m_raddr = RPC; m_inst = NOP; m_iaddr = 32'h0;
    lat = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n > 0) @(negedge clk);
      rst = 1'b0;
      hold = ($urandom_range(0, 9) < 6) ? 3'b000 : 3'($urandom_range(1, 7));
      jump = ($urandom_range(0, 15) == 0);
      jaddr = $urandom;
      bus.mem_gnt_i = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = $urandom;
      if (m_out) begin
        bus.mem_rvalid_i = (lat == 0);
        if (lat > 0) lat--;
      end else begin
        bus.mem_rvalid_i = ($urandom_range(0, 4) == 0);
      end
      #1;
      e_req = m_started && !m_out && (!m_valid || hold == 3'b000);
      checks++; if (bus.mem_req_o !== e_req) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", n, bus.mem_req_o, e_req); end
      checks++; if (bus.mem_addr_o !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", n, bus.mem_addr_o, m_pc); end
      checks++; if (busy !== m_out) begin errors++; $display("FAIL rnd_busy[%0d] got %b want %b", n, busy, m_out); end
      checks++; if (inst !== m_inst) begin errors++; $display("FAIL rnd_inst[%0d] got %h want %h", n, inst, m_inst); end
      checks++; if (iaddr !== m_iaddr) begin errors++; $display("FAIL rnd_iaddr[%0d] got %h want %h", n, iaddr, m_iaddr); end
      checks++; if (ivalid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, ivalid, m_valid); end
      @(posedge clk);
      model_step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_jump_wait();
    test_jump_grant();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
